// File: rtl/io_timer_intc.sv
// io_timer_intc: memory-mapped countdown timer with a single-source interrupt request controller.
// Build option: define IO_TIMER_VECTOR_EN to drive VECTOR on io_out while the CPU acknowledges.
//
// state | meaning
// IDLE  | no request outstanding; waits for PEND & IE
// REQ   | intr asserted toward the CPU, waiting for inta
// ACK   | acknowledge accepted (PEND cleared), waiting for inta release
module io_timer_intc #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0F00,
    parameter int unsigned PRESCALE  = 1,
    parameter logic [31:0] VECTOR    = 32'h0000_0200
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        io_cs,
    input  logic        io_rd,
    input  logic        io_wr,
    input  logic [31:0] io_address,
    input  logic [31:0] io_d_in,
    output logic [31:0] io_out,
    output logic        intr,
    input  logic        inta
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    localparam logic [1:0]  REG_CTRL   = 2'd0;
    localparam logic [1:0]  REG_LOAD   = 2'd1;
    localparam logic [1:0]  REG_COUNT  = 2'd2;
    localparam logic [1:0]  REG_STATUS = 2'd3;
    localparam logic [15:0] PRESC_TC   = 16'(PRESCALE - 1);

    state_t      state;
    logic        ctrl_en;
    logic        ctrl_auto;
    logic        ctrl_ie;
    logic [31:0] load_q;
    logic [31:0] count_q;
    logic [15:0] presc_q;
    logic        pend;
    logic        ovr;

    logic        hit;
    logic [1:0]  reg_sel;
    logic        wr_hit;
    logic        wr_ctrl;
    logic        wr_load;
    logic        wr_status;
    logic        active;
    logic        tick;
    logic        expiry;
    logic        ack_edge;
    logic        pend_clr;
    logic        ovr_clr;

    assign hit       = io_cs && (io_address[31:4] == BASE_ADDR[31:4]);
    assign reg_sel   = io_address[3:2];
    assign wr_hit    = hit && io_wr;
    assign wr_ctrl   = wr_hit && (reg_sel == REG_CTRL);
    assign wr_load   = wr_hit && (reg_sel == REG_LOAD);
    assign wr_status = wr_hit && (reg_sel == REG_STATUS);

    // The prescaler only runs while there is something left to count.
    assign active    = ctrl_en && (count_q != 32'd0);
    assign tick      = active && (presc_q == PRESC_TC);
    assign expiry    = tick && (count_q == 32'd1);

    assign ack_edge  = (state == ST_REQ) && inta;
    assign pend_clr  = ack_edge || (wr_status && io_d_in[0]);
    assign ovr_clr   = wr_status && io_d_in[1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_en   <= 1'b0;
            ctrl_auto <= 1'b0;
            ctrl_ie   <= 1'b0;
        end else if (wr_ctrl) begin
            // A CTRL write on the expiry edge overrides the one-shot auto-clear.
            ctrl_en   <= io_d_in[0];
            ctrl_auto <= io_d_in[1];
            ctrl_ie   <= io_d_in[2];
        end else if (expiry && !ctrl_auto) begin
            ctrl_en   <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            load_q  <= 32'd0;
            count_q <= 32'd0;
            presc_q <= 16'd0;
        end else if (wr_load) begin
            load_q  <= io_d_in;
            count_q <= io_d_in;
            presc_q <= 16'd0;
        end else begin
            if (active) begin
                presc_q <= (presc_q == PRESC_TC) ? 16'd0 : presc_q + 16'd1;
            end
            if (tick) begin
                if (count_q == 32'd1) begin
                    count_q <= ctrl_auto ? load_q : 32'd0;
                end else begin
                    count_q <= count_q - 32'd1;
                end
            end
        end
    end

    // A new expiry always beats a clear landing on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend <= 1'b0;
            ovr  <= 1'b0;
        end else begin
            if (expiry) begin
                pend <= 1'b1;
            end else if (pend_clr) begin
                pend <= 1'b0;
            end
            if (expiry && pend) begin
                ovr <= 1'b1;
            end else if (ovr_clr) begin
                ovr <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            intr  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pend && ctrl_ie) begin
                        state <= ST_REQ;
                        intr  <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (inta) begin
                        state <= ST_ACK;
                        intr  <= 1'b0;
                    end else if (!pend || !ctrl_ie) begin
                        state <= ST_IDLE;
                        intr  <= 1'b0;
                    end
                end
                ST_ACK: begin
                    intr <= 1'b0;
                    if (!inta) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    intr  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        io_out = 32'd0;
        if (hit && io_rd && !io_wr) begin
            case (reg_sel)
                REG_CTRL:   io_out = {29'd0, ctrl_ie, ctrl_auto, ctrl_en};
                REG_LOAD:   io_out = load_q;
                REG_COUNT:  io_out = count_q;
                REG_STATUS: io_out = {30'd0, ovr, pend};
                default:    io_out = 32'd0;
            endcase
        end
`ifdef IO_TIMER_VECTOR_EN
        if ((state == ST_ACK) && inta) begin
            io_out = VECTOR;
        end
`endif
    end

`ifdef IO_TIMER_VECTOR_EN
    logic unused_ok;
    assign unused_ok = ^io_address[1:0];
`else
    logic unused_ok;
    assign unused_ok = ^{VECTOR, io_address[1:0]};
`endif

endmodule

// File: tb/tb_io_timer_intc.sv
// tb_io_timer_intc: directed bench for io_timer_intc; instance A uses PRESCALE=1, instance B PRESCALE=4.
module tb_io_timer_intc;

    localparam logic [31:0] BASE_A = 32'h0000_0F00;
    localparam logic [31:0] BASE_B = 32'h0000_0E00;
    localparam logic [31:0] VEC    = 32'h0000_0200;

    logic        clk;
    logic        reset;
    logic        io_cs;
    logic        io_rd;
    logic        io_wr;
    logic [31:0] io_address;
    logic [31:0] io_d_in;
    logic [31:0] io_out_a;
    logic [31:0] io_out_b;
    logic        intr_a;
    logic        intr_b;
    logic        inta_a;
    logic        inta_b;

    int n_tests = 0;
    int n_fail  = 0;

    io_timer_intc #(.BASE_ADDR(BASE_A), .PRESCALE(1), .VECTOR(VEC)) dut_a (
        .clk(clk), .reset(reset), .io_cs(io_cs), .io_rd(io_rd), .io_wr(io_wr),
        .io_address(io_address), .io_d_in(io_d_in), .io_out(io_out_a),
        .intr(intr_a), .inta(inta_a)
    );

    io_timer_intc #(.BASE_ADDR(BASE_B), .PRESCALE(4), .VECTOR(VEC)) dut_b (
        .clk(clk), .reset(reset), .io_cs(io_cs), .io_rd(io_rd), .io_wr(io_wr),
        .io_address(io_address), .io_d_in(io_d_in), .io_out(io_out_b),
        .intr(intr_b), .inta(inta_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        io_cs      = 1'b1;
        io_wr      = 1'b1;
        io_address = addr;
        io_d_in    = data;
        @(posedge clk);
        #1;
        io_cs = 1'b0;
        io_wr = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        io_cs      = 1'b1;
        io_rd      = 1'b1;
        io_address = addr;
        #1;
        data  = io_out_a | io_out_b;
        io_cs = 1'b0;
        io_rd = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] rd;
    bit          seen;

    initial begin
        reset      = 1'b0;
        io_cs      = 1'b0;
        io_rd      = 1'b0;
        io_wr      = 1'b0;
        io_address = 32'd0;
        io_d_in    = 32'd0;
        inta_a     = 1'b0;
        inta_b     = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        cyc();

        // reset values
        bus_read(BASE_A + 32'h0, rd); chk("rst_ctrl", rd, 32'h0);
        bus_read(BASE_A + 32'h4, rd); chk("rst_load", rd, 32'h0);
        bus_read(BASE_A + 32'h8, rd); chk("rst_count", rd, 32'h0);
        bus_read(BASE_A + 32'hC, rd); chk("rst_status", rd, 32'h0);
        chk("rst_intr", {31'd0, intr_a}, 32'h0);
        chk("rst_io_out_idle", io_out_a, 32'h0);

        // inta while idle is ignored
        @(negedge clk); inta_a = 1'b1;
        cyc();
        @(negedge clk); inta_a = 1'b0;
        cyc();
        chk("idle_inta_intr", {31'd0, intr_a}, 32'h0);
        bus_read(BASE_A + 32'hC, rd); chk("idle_inta_status", rd, 32'h0);

        // one-shot expiry
        bus_write(BASE_A + 32'h4, 32'd3);
        bus_write(BASE_A + 32'h0, 32'd5);
        bus_read(BASE_A + 32'h8, rd); chk("os_count3", rd, 32'd3);
        for (int i = 2; i >= 0; i--) begin
            cyc();
            bus_read(BASE_A + 32'h8, rd); chk("os_count", rd, 32'(i));
        end
        bus_read(BASE_A + 32'hC, rd); chk("os_pend", rd, 32'h1);
        chk("os_intr_not_yet", {31'd0, intr_a}, 32'h0);
        cyc();
        chk("os_intr", {31'd0, intr_a}, 32'h1);
        bus_read(BASE_A + 32'h0, rd); chk("os_ctrl", rd, 32'h4);

        // handshake
        @(negedge clk); inta_a = 1'b1;
        cyc();
        chk("hs_intr_drop", {31'd0, intr_a}, 32'h0);
        bus_read(BASE_A + 32'hC, rd); chk("hs_status", rd, 32'h0);
        cyc();
`ifdef IO_TIMER_VECTOR_EN
        chk("hs_vector", io_out_a, VEC);
`else
        chk("hs_no_vector", io_out_a, 32'h0);
`endif
        @(negedge clk); inta_a = 1'b0;
        cyc();
        chk("hs_io_out_release", io_out_a, 32'h0);
        repeat (3) cyc();
        chk("hs_no_rereq", {31'd0, intr_a}, 32'h0);

        // auto-reload and overrun
        bus_write(BASE_A + 32'h4, 32'd2);
        bus_write(BASE_A + 32'h0, 32'd7);
        cyc();
        bus_read(BASE_A + 32'h8, rd); chk("ar_count1", rd, 32'd1);
        cyc();
        bus_read(BASE_A + 32'hC, rd); chk("ar_pend", rd, 32'h1);
        bus_read(BASE_A + 32'h8, rd); chk("ar_reload", rd, 32'd2);
        cyc();
        chk("ar_intr", {31'd0, intr_a}, 32'h1);
        cyc();
        bus_read(BASE_A + 32'hC, rd); chk("ar_ovr", rd, 32'h3);
        bus_write(BASE_A + 32'hC, 32'd3);
        bus_read(BASE_A + 32'hC, rd); chk("ar_w1c", rd, 32'h0);
        cyc();
        chk("ar_intr_drop", {31'd0, intr_a}, 32'h0);
        bus_write(BASE_A + 32'h0, 32'd0);
        bus_write(BASE_A + 32'hC, 32'd3);
        repeat (2) cyc();
        chk("ar_stopped_intr", {31'd0, intr_a}, 32'h0);
        bus_read(BASE_A + 32'hC, rd); chk("ar_stopped_status", rd, 32'h0);

        // prescaler on instance B
        bus_write(BASE_B + 32'h4, 32'd2);
        bus_write(BASE_B + 32'h0, 32'd1);
        repeat (3) cyc();
        bus_read(BASE_B + 32'h8, rd); chk("ps_count_hold", rd, 32'd2);
        cyc();
        bus_read(BASE_B + 32'h8, rd); chk("ps_count_dec", rd, 32'd1);
        bus_write(BASE_B + 32'h8, 32'd9);
        bus_read(BASE_B + 32'h8, rd); chk("ps_count_ro", rd, 32'd1);
        repeat (2) cyc();
        bus_read(BASE_B + 32'hC, rd); chk("ps_no_pend_yet", rd, 32'h0);
        cyc();
        bus_read(BASE_B + 32'hC, rd); chk("ps_pend", rd, 32'h1);
        bus_read(BASE_B + 32'h8, rd); chk("ps_count0", rd, 32'd0);
        bus_read(BASE_B + 32'h0, rd); chk("ps_ctrl", rd, 32'h0);
        chk("ps_intr_masked", {31'd0, intr_b}, 32'h0);

        // reset mid-request
        bus_write(BASE_A + 32'h4, 32'd1);
        bus_write(BASE_A + 32'h0, 32'd5);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            cyc();
            if (intr_a) seen = 1'b1;
        end
        chk("mr_intr_seen", {31'd0, seen}, 32'h1);
        #2;
        reset = 1'b0;
        #1;
        chk("mr_intr_async", {31'd0, intr_a}, 32'h0);
        bus_read(BASE_A + 32'h0, rd); chk("mr_ctrl", rd, 32'h0);
        bus_read(BASE_A + 32'h4, rd); chk("mr_load", rd, 32'h0);
        bus_read(BASE_A + 32'h8, rd); chk("mr_count", rd, 32'h0);
        bus_read(BASE_A + 32'hC, rd); chk("mr_status", rd, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) cyc();
        chk("mr_after_intr", {31'd0, intr_a}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/io_timer_intc.md
Name: io_timer_intc

Overview:
Memory-mapped countdown timer with an interrupt-request controller, attached to the CPU's IO bus (io_cs/io_rd/io_wr, shared dm_address/dm_d_in).
- Drives io_out for register reads.
- Raises intr toward the CPU and completes the intr/inta handshake.
- Gives the IO space a programmable, periodic interrupt source for exercising the CPU's interrupt path.

Parameters:
BASE_ADDR, 32'h0000_0F00, base of a 16-byte register window; BASE_ADDR[3:0] must be 0
PRESCALE, 1, clock ticks per COUNT decrement; legal range 1..65535
VECTOR, 32'h0000_0200, word driven on io_out during the interrupt acknowledge (optional feature only)

Ports:
clk  in  1  system clock; all state changes on rising edge
reset  in  1  asynchronous, active-low reset
io_cs  in  1  IO chip select
io_rd  in  1  IO read strobe
io_wr  in  1  IO write strobe
io_address  in  32  byte address; [31:4] selects the window, [3:2] selects the register, [1:0] ignored
io_d_in  in  32  write data from the CPU
io_out  out  32  read data to the CPU
intr  out  1  interrupt request to the CPU
inta  in  1  interrupt acknowledge from the CPU

Behaviour:
- Reset (reset=0, asynchronous): CTRL, LOAD, COUNT, STATUS and the prescaler are cleared to 0; FSM goes to IDLE; intr=0; io_out=0.
- Hit condition: hit = io_cs & (io_address[31:4]==BASE_ADDR[31:4]).
- Register map (offset = io_address[3:2]):
  - 0 CTRL: [0] EN, [1] AUTO (reload), [2] IE; [31:3] read as 0.
  - 1 LOAD: 32-bit reload value. Writing LOAD also loads COUNT with the same value and clears the prescaler.
  - 2 COUNT: read-only; writes are ignored.
  - 3 STATUS: [0] PEND, [1] OVR. Write-1-to-clear per bit.
- Writes: take effect on the rising edge when hit & io_wr.
- Reads: combinational. io_out = selected register when hit & io_rd & ~io_wr; otherwise 32'h0. io_out is never high-Z.
- Prescaler:
  - Increments each cycle while EN=1 and COUNT!=0.
  - On reaching PRESCALE-1 it wraps to 0 and issues a tick.
  - With PRESCALE=1, every cycle is a tick.
- Tick: COUNT <= COUNT-1.
- Expiry = a tick with COUNT==1. On that edge:
  - PEND <= 1. If PEND was already 1, OVR <= 1 as well.
  - If AUTO=1: COUNT <= LOAD. If LOAD==0, the timer idles at 0.
  - If AUTO=0: COUNT <= 0 and EN <= 0.
- EN=1 with COUNT==0: no ticks and no expiry.
- Simultaneous events:
  - Expiry and a STATUS W1C on the same edge: the set wins; PEND=1.
  - A CTRL write on the same edge as an expiry with AUTO=0: the written CTRL value wins over the auto-clear of EN.
- Interrupt FSM (intr is registered; intr=1 only in REQ):
  - IDLE -> REQ when PEND & IE. intr rises one cycle after PEND is seen.
  - REQ -> ACK when inta=1. PEND is cleared on that edge and intr drops on the same edge.
  - REQ -> IDLE if PEND or IE becomes 0 (W1C or CTRL write) before inta.
  - ACK -> IDLE when inta=0. A new PEND set during ACK is held and re-requested from IDLE.
- inta asserted while in IDLE is ignored.
- Reset mid-operation: all state is cleared immediately, including during REQ/ACK; intr drops asynchronously.

Optional Feature:
IO_TIMER_VECTOR_EN
- Defined: while the FSM is in ACK and inta=1, io_out = VECTOR regardless of io_cs/io_rd. This has priority over register reads.
- Undefined: inta does not affect io_out, and the VECTOR parameter is unused.

Test Plan:
- Reset values: hold reset=0, then release; read CTRL, LOAD, COUNT, STATUS -> all 32'h0, intr=0, io_out=0 when idle.
- One-shot expiry (PRESCALE=1): write LOAD=3, then CTRL=5 (EN|IE). COUNT reads 3,2,1,0 on consecutive cycles. PEND=1 on the 0 edge, intr=1 one cycle later, CTRL reads 4 (EN cleared).
- Handshake: while intr=1, drive inta=1 for 2 cycles, then 0. intr drops on the first inta edge, STATUS reads 0, FSM returns to IDLE, and no re-request occurs.
- Auto-reload and overrun: LOAD=2, CTRL=7, never acknowledge. PEND sets every 2 cycles and OVR=1 after the second expiry. Write STATUS=3 -> reads 0, intr=0 next cycle.
- Prescaler: with PRESCALE=4, LOAD=2, CTRL=1, COUNT decrements every 4 cycles and expiry occurs 8 cycles after the enable edge. Writing COUNT=9 mid-run -> no effect.
- Reset mid-request and vector:
  - Assert reset=0 while intr=1 -> intr=0 immediately and all registers read 0.
  - With IO_TIMER_VECTOR_EN defined, io_out=32'h0000_0200 while inta=1 in ACK.
